// File: rtl/ibex_instr_resp_pkg.sv
// rtl/ibex_instr_resp_pkg.sv - shared types, constants and helpers for the instruction memory responder
//
// Purpose: response-slot type, LFSR constants, default region constants and
// the overflow-free region check used by the responder.
// Ports: none (package).
package ibex_instr_resp_pkg;

  // One entry of the gnt-to-rvalid delay line.
  typedef struct packed {
    logic valid;
    logic err;
  } resp_slot_t;

  // Polynomial x^16 + x^14 + x^13 + x^11 + 1, left-shifting form: taps at bits 15,13,12,10.
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ADDR_SIZE = 32'h0001_0000;

  // 33-bit compare so a region ending at 2^32 neither wraps nor aliases low addresses.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return ({1'b0, addr} >= {1'b0, base}) && (off < {1'b0, size});
  endfunction

endpackage

// File: rtl/ibex_instr_resp_lfsr.sv
// rtl/ibex_instr_resp_lfsr.sv - 16-bit Fibonacci LFSR used to generate grant stalls
//
// Purpose: free-running pseudo-random source; loads seed_i while rst_i is high.
// Ports:
//   clk_i   in  clock
//   rst_i   in  synchronous active-high reset (loads seed)
//   seed_i  in  LFSR_W  reset value, must be nonzero
//   en_i    in  advance enable
//   state_o out LFSR_W  current register contents
module ibex_instr_resp_lfsr
  import ibex_instr_resp_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              en_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= seed_i;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// rtl/ibex_instr_mem_responder.sv - instruction-fetch req/gnt/rvalid responder in front of a fixed-latency SRAM
//
// Purpose: grants fetch requests (bounded by MAX_OUTSTANDING), range-checks
// the address, issues SRAM reads for in-range fetches and returns in-order
// responses exactly MEM_LATENCY cycles after grant, flagging err for
// out-of-range fetches.
// Optional: define IBEX_INSTR_RESP_STALL_EN to withhold grant pseudo-randomly.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   instr_req_i/addr_i    fetch request and byte address ([1:0] ignored)
//   instr_gnt_o           combinational grant
//   instr_rvalid_o/rdata_o/err_o  response
//   mem_req_o/addr_o      SRAM read strobe and word address
//   mem_rdata_i           SRAM data, MEM_LATENCY cycles after mem_req_o
//   outstanding_o         granted-but-unanswered count
module ibex_instr_mem_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ADDR_BASE       = DEFAULT_ADDR_BASE,
  parameter logic [31:0] ADDR_SIZE       = DEFAULT_ADDR_SIZE,
  parameter int unsigned MEM_AW          = 14,
  parameter logic [15:0] STALL_SEED      = 16'hACE1,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [CNT_W-1:0]  outstanding_o
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

  logic             stall;
  logic             in_range;
  logic [31:0]      offset;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  resp_slot_t       pipe_q [MEM_LATENCY];
  resp_slot_t       pipe_d [MEM_LATENCY];
  resp_slot_t       last_slot;

`ifdef IBEX_INSTR_RESP_STALL_EN
  logic [LFSR_W-1:0] lfsr_state;
  logic              unused_lfsr_bits;

  ibex_instr_resp_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .seed_i  (STALL_SEED),
    .en_i    (1'b1),
    .state_o (lfsr_state)
  );

  assign stall            = (lfsr_state[1:0] == 2'b00);
  assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:2];
`else
  logic unused_stall_seed;

  assign stall             = 1'b0;
  assign unused_stall_seed = ^STALL_SEED;
`endif

  // Request side: everything here is combinational on the current request.
  assign in_range    = in_region(instr_addr_i, ADDR_BASE, ADDR_SIZE);
  assign offset      = instr_addr_i - ADDR_BASE;
  assign instr_gnt_o = instr_req_i & (cnt_q < MAX_OUT_C) & ~stall;
  assign mem_req_o   = instr_gnt_o & in_range;
  assign mem_addr_o  = offset[MEM_AW+1:2];

  // Only the word-index bits of the offset address the SRAM.
  logic unused_offset;
  assign unused_offset = ^offset;

  // Delay line matching SRAM latency; error fetches occupy a slot to keep order.
  always_comb begin
    pipe_d[0] = '{valid: instr_gnt_o, err: ~in_range};
    for (int k = 1; k < int'(MEM_LATENCY); k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  assign last_slot      = pipe_q[MEM_LATENCY-1];
  assign instr_rvalid_o = last_slot.valid;
  assign instr_err_o    = last_slot.valid & last_slot.err;
  assign instr_rdata_o  = (last_slot.valid & ~last_slot.err) ? mem_rdata_i : 32'h0;

  always_comb begin
    cnt_d = cnt_q;
    if (instr_gnt_o && !instr_rvalid_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!instr_gnt_o && instr_rvalid_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int k = 0; k < int'(MEM_LATENCY); k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      pipe_q <= pipe_d;
    end
  end

  assign outstanding_o = cnt_q;

`ifndef SYNTHESIS
  a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= MAX_OUT_C);
  a_rvalid_cnt : assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_o |-> (cnt_q != '0));
  a_addr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (instr_req_i & ~instr_gnt_o) |=> $stable(instr_addr_i))
    else $warning("instr_addr_i changed while request pending");
`endif

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// tb/tb_ibex_instr_mem_responder.sv - self-checking bench for ibex_instr_mem_responder
module tb_ibex_instr_mem_responder;

  localparam int N = 3;
  localparam int          LAT  [N] = '{1, 2, 1};
  localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000};
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [N];
  logic [31:0] addr   [N];
  logic        gnt    [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        err    [N];
  logic        mreq   [N];
  logic [13:0] maddr  [N];
  logic [31:0] mrdata [N];
  logic [1:0]  outst  [N];

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   peak   = 0;

  function automatic logic [31:0] word_val(input logic [13:0] w);
    if (w == 14'h040) return 32'h0041_0113;
    return {2'b10, w, 2'b01, w};
  endfunction

  ibex_instr_mem_responder #(.MEM_LATENCY(1), .MAX_OUTSTANDING(2), .ADDR_BASE(32'h0000_0000),
                             .ADDR_SIZE(32'h0001_0000), .MEM_AW(14)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]),
    .mem_rdata_i(mrdata[0]), .outstanding_o(outst[0]));

  ibex_instr_mem_responder #(.MEM_LATENCY(2), .MAX_OUTSTANDING(2), .ADDR_BASE(32'h0000_0000),
                             .ADDR_SIZE(32'h0001_0000), .MEM_AW(14)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]),
    .mem_rdata_i(mrdata[1]), .outstanding_o(outst[1]));

  ibex_instr_mem_responder #(.MEM_LATENCY(1), .MAX_OUTSTANDING(2), .ADDR_BASE(32'hFFFF_0000),
                             .ADDR_SIZE(32'h0001_0000), .MEM_AW(14)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]),
    .instr_err_o(err[2]), .mem_req_o(mreq[2]), .mem_addr_o(maddr[2]),
    .mem_rdata_i(mrdata[2]), .outstanding_o(outst[2]));

  // SRAM models: data for a strobe seen at edge T appears LAT cycles later; garbage otherwise.
  for (genvar g = 0; g < N; g++) begin : g_sram
    logic [31:0] dl [4];
    always @(posedge clk) begin
      dl[0] <= mreq[g] ? word_val(maddr[g]) : 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) dl[k] <= dl[k-1];
    end
    assign mrdata[g] = dl[LAT[g]-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance idx: drive, sample at negedge, score, advance.
  task automatic cycle(input int idx, input logic rq, input logic [31:0] a, output logic g);
    logic        exp_g, exp_rv, inr;
    logic [32:0] off;
    exp_t        e;
    req[idx]  = rq;
    addr[idx] = a;
    @(negedge clk);
    off    = {1'b0, a} - {1'b0, BASE[idx]};
    inr    = ({1'b0, a} >= {1'b0, BASE[idx]}) && (off < {1'b0, SIZE});
    exp_g  = rq && (sb.size() < 2);
    exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
    chk("gnt", 32'(gnt[idx]), 32'(exp_g));
    chk("outstanding", 32'(outst[idx]), 32'(sb.size()));
    chk("mem_req", 32'(mreq[idx]), 32'(exp_g && inr));
    if (exp_g && inr) chk("mem_addr", 32'(maddr[idx]), 32'(off[15:2]));
    chk("rvalid", 32'(rvalid[idx]), 32'(exp_rv));
    if (exp_rv) begin
      e = sb.pop_front();
      chk("err", 32'(err[idx]), 32'(e.err));
      chk("rdata", rdata[idx], e.data);
    end else begin
      chk("err_idle", 32'(err[idx]), 32'h0);
      chk("rdata_idle", rdata[idx], 32'h0);
    end
    if (exp_g) begin
      e.due  = cyc + LAT[idx];
      e.err  = !inr;
      e.data = inr ? word_val(off[15:2]) : 32'h0;
      sb.push_back(e);
    end
    if (int'(outst[idx]) > peak) peak = int'(outst[idx]);
    g = gnt[idx];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fetch(input int idx, input logic [31:0] a, output int gc);
    logic g;
    g  = 1'b0;
    gc = -1;
    for (int i = 0; i < 8 && !g; i++) begin
      gc = cyc;
      cycle(idx, 1'b1, a, g);
    end
    chk("gnt_within_bound", 32'(g), 32'h1);
  endtask

  task automatic drain(input int idx);
    logic g;
    for (int i = 0; i < 12 && sb.size() > 0; i++) cycle(idx, 1'b0, 32'h0, g);
    chk("drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int   gc0, gc1, gc2, gc3, start;
    logic g;
    for (int i = 0; i < N; i++) begin
      req[i]  = 1'b0;
      addr[i] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: latency-1 fetch straight out of reset; reset outputs checked in the same cycle.
    fetch(0, 32'h0000_0100, gc0);
    drain(0);

    // 2: held request, latency 2, two outstanding max.
    peak  = 0;
    start = cyc;
    fetch(1, 32'h0000_0000, gc0);
    fetch(1, 32'h0000_0004, gc1);
    fetch(1, 32'h0000_0008, gc2);
    fetch(1, 32'h0000_000C, gc3);
    chk("gnt_cycle0", 32'(gc0 - start), 32'd0);
    chk("gnt_cycle1", 32'(gc1 - start), 32'd1);
    chk("gnt_cycle2", 32'(gc2 - start), 32'd3);
    chk("gnt_cycle3", 32'(gc3 - start), 32'd4);
    drain(1);
    chk("peak_outstanding", 32'(peak), 32'd2);

    // 3: out-of-range fetch.
    fetch(1, 32'h0002_0000, gc0);
    drain(1);

    // 4: good / bad / good back to back.
    fetch(1, 32'h0000_0000, gc0);
    fetch(1, 32'h0003_0000, gc0);
    fetch(1, 32'h0000_0004, gc0);
    drain(1);

    // Region edges: last word in range, first word past the end.
    fetch(1, 32'h0000_FFFC, gc0);
    fetch(1, 32'h0001_0000, gc0);
    drain(1);

    // 5: reset the cycle after a grant; the response must vanish.
    fetch(1, 32'h0000_0010, gc0);
    rst    = 1'b1;
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    sb.delete();
    cycle(1, 1'b1, 32'h0000_0014, g);
    chk("gnt_after_reset", 32'(g), 32'h1);
    drain(1);

    // 6: region ending at 2^32.
    fetch(2, 32'hFFFF_FFFC, gc0);
    fetch(2, 32'hFFFE_FFFC, gc0);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
